// File: rtl/sbus_encoder.sv
// rtl/sbus_encoder.sv - S-Bus frame generator feeding a UART transmitter byte stream
// Emits one 25-byte frame (0xF0, 22 data bytes, flags, 0x00) per frame period while enabled.
module sbus_encoder #(
    parameter int unsigned FRAME_PERIOD_TICKS = 1400000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic [175:0] channels_i,
    input  logic [7:0]   flags_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic         busy_o,
    output logic         frame_done_o
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_SEND   = 1'b1;
    localparam logic [31:0] TIMER_MAX = 32'(FRAME_PERIOD_TICKS - 1);
    localparam logic [4:0]  LAST_IDX  = 5'd24;
    localparam logic [7:0]  SYNC_BYTE = 8'hF0;
    localparam logic [7:0]  END_BYTE  = 8'h00;

    logic [0:0]   state_q, state_d;
    logic [31:0]  timer_q, timer_d;
    logic [4:0]   byte_idx_q, byte_idx_d;
    logic [175:0] chan_q, chan_d;
    logic [7:0]   flags_q, flags_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_valid_q, tx_valid_d;
    logic         done_q, done_d;

    logic [175:0] stream;
    logic         start;
    logic         accept;

    // Bit-reversing each 11-bit channel and concatenating ch1 first is the same as
    // reversing the whole 176-bit channel vector.
    always_comb begin
        stream = '0;
        for (int i = 0; i < 176; i++) begin
            stream[175 - i] = chan_q[i];
        end
    end

    function automatic logic [7:0] frame_byte(input logic [4:0]   idx,
                                              input logic [175:0] s,
                                              input logic [7:0]   fl);
        logic [7:0] b;
        if (idx == 5'd0) begin
            b = SYNC_BYTE;
        end else if (idx <= 5'd22) begin
            b = 8'(s >> (9'd176 - 9'({idx, 3'b000})));
        end else if (idx == 5'd23) begin
            b = fl;
        end else begin
            b = END_BYTE;
        end
        return b;
    endfunction

    assign start  = (state_q == ST_IDLE) && enable_i && (timer_q == TIMER_MAX);
    assign accept = tx_valid_q && tx_ready_i;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        chan_d     = chan_q;
        flags_d    = flags_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;

        if (start) begin
            timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chan_d     = channels_i;
                    flags_d    = flags_i;
                    byte_idx_d = '0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (byte_idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Load the next byte on the accepting edge so ready=1 streams without gaps.
                        byte_idx_d = byte_idx_q + 5'd1;
                        tx_data_d  = frame_byte(byte_idx_q + 5'd1, stream, flags_q);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            byte_idx_q <= '0;
            chan_q     <= '0;
            flags_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            byte_idx_q <= byte_idx_d;
            chan_q     <= chan_d;
            flags_q    <= flags_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign busy_o       = (state_q == ST_SEND);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_sbus_encoder.sv
// tb/tb_sbus_encoder.sv - directed and randomized checks of sbus_encoder frames against a frame model
module tb_sbus_encoder;

    localparam int P = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [175:0] channels;
    logic [7:0]   flags;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int f_start;
    int f_end;
    int ready_mode = 0;
    int drop_at = 0;
    bit churn = 1'b0;
    logic [7:0] exp_b [25];
    logic [7:0] got_b [25];

    sbus_encoder #(.FRAME_PERIOD_TICKS(P)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .channels_i   (channels),
        .flags_i      (flags),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame built straight from the byte-map rules: reversed channels, ch1 first, MSB-first slicing.
    task automatic model(input logic [175:0] ch, input logic [7:0] fl);
        logic [175:0] s;
        logic [10:0]  ck, rk;
        s = '0;
        for (int k = 1; k <= 16; k++) begin
            ck = ch[11*k-1 -: 11];
            for (int j = 0; j < 11; j++) rk[10-j] = ck[j];
            s = (s << 11) | 176'(rk);
        end
        exp_b[0] = 8'hF0;
        for (int n = 1; n <= 22; n++) exp_b[n] = 8'(s >> (176 - 8*n));
        exp_b[23] = fl;
        exp_b[24] = 8'h00;
    endtask

    function automatic logic [175:0] rand_ch();
        return 176'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic recv_frame(input string tag);
        int n = 0;
        int bad_stable = 0;
        int overlap = 0;
        int busy_bad = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_d = '0;
        f_start = -1;
        f_end = -1;
        for (int g = 0; g < 4000 && n < 25; g++) begin
            @(negedge clk);
            if (tx_valid && f_start < 0) f_start = cyc;
            if (prev_stall && !(tx_valid && tx_data == prev_d)) bad_stable++;
            if (tx_valid && frame_done) overlap++;
            if (f_start >= 0 && !busy) busy_bad++;
            if (churn && f_start >= 0) begin
                channels = rand_ch();
                flags = 8'($urandom);
            end
            tx_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                got_b[n] = tx_data;
                n++;
                f_end = cyc;
                if (drop_at != 0 && n == drop_at) enable = 1'b0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_d = tx_data;
        end
        check({tag, " bytes_accepted"}, 32'(n), 32'd25);
        check({tag, " data_stable"}, 32'(bad_stable), 32'd0);
        check({tag, " done_valid_overlap"}, 32'(overlap), 32'd0);
        check({tag, " busy_in_frame"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        check({tag, " frame_done"}, 32'(frame_done), 32'd1);
        check({tag, " valid_after_end"}, 32'(tx_valid), 32'd0);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("%s byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
        end
    endtask

    initial begin
        int rel, s1, c0, seen, n;
        rst_n = 1'b0;
        enable = 1'b0;
        channels = '0;
        flags = '0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);

        // Scenario 1: zero frame, period spacing, latency from reset release
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        model('0, 8'h00);
        recv_frame("s1a");
        check("s1 first_f0_latency", 32'(f_start - rel), 32'(P));
        check("s1 back_to_back", 32'(f_end - f_start), 32'd24);
        s1 = f_start;
        recv_frame("s1b");
        check("s1 period", 32'(f_start - s1), 32'(P));

        // Scenario 2: single-bit channel extremes
        channels = '0;
        channels[10:0] = 11'h001;
        channels[175:165] = 11'h400;
        flags = 8'h0C;
        model(channels, flags);
        recv_frame("s2");
        check("s2 byte1", 32'(got_b[1]), 32'h80);
        check("s2 byte22", 32'(got_b[22]), 32'h01);
        check("s2 byte23", 32'(got_b[23]), 32'h0C);

        // Scenario 3: same frame under random backpressure
        ready_mode = 1;
        recv_frame("s3");

        // Scenario 4: inputs churn during SEND
        channels = rand_ch();
        flags = 8'($urandom);
        model(channels, flags);
        churn = 1'b1;
        recv_frame("s4");
        churn = 1'b0;

        // Scenario 5: random content frames
        for (int f = 0; f < 8; f++) begin
            channels = rand_ch();
            flags = 8'($urandom);
            model(channels, flags);
            recv_frame($sformatf("s5f%0d", f));
        end

        // Scenario 6a: disable mid-frame, then immediate start after long idle
        channels = rand_ch();
        flags = 8'($urandom);
        model(channels, flags);
        drop_at = 10;
        recv_frame("s6a");
        drop_at = 0;
        seen = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (tx_valid || busy) seen++;
        end
        check("s6a no_frame_when_disabled", 32'(seen), 32'd0);
        enable = 1'b1;
        c0 = cyc;
        recv_frame("s6a_restart");
        check("s6a start_after_idle", 32'(f_start - c0), 32'd1);

        // Scenario 6b: reset mid-frame aborts immediately
        ready_mode = 0;
        n = 0;
        for (int g = 0; g < 4 * P && n < 5; g++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            if (tx_valid) n++;
        end
        check("s6b bytes_before_reset", 32'(n), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s6b reset tx_valid", 32'(tx_valid), 32'd0);
        check("s6b reset busy", 32'(busy), 32'd0);
        check("s6b reset tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        channels = rand_ch();
        flags = 8'($urandom);
        model(channels, flags);
        recv_frame("s6b_after");
        check("s6b first_f0_latency", 32'(f_start - rel), 32'(P));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
